// File: rtl/ms7210_init_seq.sv
// MS7210 HDMI transmitter power-up sequencer: hardware reset pulse, settle
// wait, then a table-driven walk of I2C register writes with retry on NACK.
module ms7210_init_seq #(
    parameter int         RST_HOLD_CYC = 50000,
    parameter int         RST_WAIT_CYC = 500000,
    parameter int         DLY_UNIT_CYC = 50000,
    parameter int         TBL_LEN      = 64,
    parameter int         IDX_W        = 8,
    parameter logic [6:0] DEV_ADDR     = 7'h59,
    parameter int         MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic             rstn_out,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [23:0]      tbl_data,
    output logic             i2c_req,
    output logic [6:0]       i2c_dev_addr,
    output logic [15:0]      i2c_reg_addr,
    output logic [7:0]       i2c_wdata,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             init_over,
    output logic             init_err
);

    localparam int RST_MAX = (RST_HOLD_CYC > RST_WAIT_CYC) ?
                             RST_HOLD_CYC : RST_WAIT_CYC;
    localparam int RCNT_W  = $clog2(RST_MAX + 1);
    localparam int DCNT_W  = $clog2(255 * DLY_UNIT_CYC + 1);
    localparam int RTRY_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_RST_HOLD,
        S_RST_WAIT,
        S_FETCH,
        S_LOAD,
        S_WRITE,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    logic [RCNT_W-1:0] r_rst_cnt;
    logic [DCNT_W-1:0] r_dly_cnt;
    logic [RTRY_W-1:0] r_retry;

    logic [RTRY_W-1:0] w_retry_nxt;
    logic              w_is_delay;
    logic              w_last_idx;

    assign i2c_dev_addr = DEV_ADDR;
    assign w_retry_nxt  = r_retry + RTRY_W'(1);
    assign w_is_delay   = (tbl_data[23:8] == 16'hFFFF);
    assign w_last_idx   = (tbl_idx == IDX_W'(TBL_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RST_HOLD;
            r_rst_cnt    <= '0;
            r_dly_cnt    <= '0;
            r_retry      <= '0;
            rstn_out     <= 1'b0;
            tbl_idx      <= '0;
            i2c_req      <= 1'b0;
            i2c_reg_addr <= '0;
            i2c_wdata    <= '0;
            init_over    <= 1'b0;
            init_err     <= 1'b0;
        end else begin
            unique case (r_state)
                S_RST_HOLD: begin
                    rstn_out <= 1'b0;
                    if (r_rst_cnt == RCNT_W'(RST_HOLD_CYC - 1)) begin
                        r_rst_cnt <= '0;
                        rstn_out  <= 1'b1;
                        r_state   <= S_RST_WAIT;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCNT_W'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (r_rst_cnt == RCNT_W'(RST_WAIT_CYC - 1)) begin
                        r_rst_cnt <= '0;
                        tbl_idx   <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCNT_W'(1);
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    if (w_is_delay) begin
                        r_dly_cnt <= DCNT_W'(tbl_data[7:0]) *
                                     DCNT_W'(DLY_UNIT_CYC);
                        r_state   <= (tbl_data[7:0] == 8'd0) ?
                                     S_NEXT : S_DELAY;
                    end else begin
                        i2c_reg_addr <= tbl_data[23:8];
                        i2c_wdata    <= tbl_data[7:0];
                        r_retry      <= '0;
                        i2c_req      <= 1'b1;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i2c_done) begin
                        i2c_req <= 1'b0;
                        if (!i2c_nack) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_retry <= w_retry_nxt;
                            if (w_retry_nxt == RTRY_W'(MAX_RETRY)) begin
                                init_err <= 1'b1;
                                r_state  <= S_ERROR;
                            end else begin
                                r_state  <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    i2c_req <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_DELAY: begin
                    if (r_dly_cnt <= DCNT_W'(1)) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DCNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (w_last_idx) begin
                        init_over <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        tbl_idx <= tbl_idx + IDX_W'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DONE, S_ERROR: begin
                    // Rerun repeats the chip reset pulse as well.
                    if (restart) begin
                        init_over <= 1'b0;
                        init_err  <= 1'b0;
                        tbl_idx   <= '0;
                        rstn_out  <= 1'b0;
                        r_rst_cnt <= '0;
                        r_state   <= S_RST_HOLD;
                    end
                end
                default: r_state <= S_RST_HOLD;
            endcase
        end
    end

endmodule

// File: doc/ms7210_init_seq.md
Name: ms7210_init_seq

Overview:
Power-up configuration sequencer for the MS7210 HDMI transmitter on the colorbar video path. It drives the chip's hardware reset and waits for the chip to settle. It then walks a register table (synchronous ROM, external) and issues each 16-bit-address/8-bit-data write through a byte-level I2C master via a req/done handshake. It flags completion to the top level, which gates the status LED and video bring-up.

Parameters:
RST_HOLD_CYC, 50000, cycles rstn_out is held low (1 ms at 50 MHz)
RST_WAIT_CYC, 500000, cycles waited after releasing rstn_out before the first write
DLY_UNIT_CYC, 50000, cycles per unit of a delay table entry
TBL_LEN, 64, number of table entries (1..2^IDX_W)
IDX_W, 8, table index width
DEV_ADDR, 7'h59, 7-bit I2C device address
MAX_RETRY, 3, NACKed attempts allowed per entry before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
restart  in  1  single-cycle pulse; reruns the full sequence from DONE or ERROR
rstn_out  out  1  MS7210 hardware reset, active low
tbl_idx  out  IDX_W  ROM address
tbl_data  in  24  ROM data, 1-cycle latency: [23:8] register address, [7:0] value
i2c_req  out  1  write request to the I2C master
i2c_dev_addr  out  7  constant DEV_ADDR
i2c_reg_addr  out  16  register address, stable while i2c_req=1
i2c_wdata  out  8  write data, stable while i2c_req=1
i2c_done  in  1  single-cycle completion pulse from the master
i2c_nack  in  1  valid only with i2c_done; 1 = transfer NACKed
init_over  out  1  sequence completed successfully
init_err  out  1  sequence aborted after retries exhausted

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: rstn_out=0, tbl_idx=0, i2c_req=0, i2c_reg_addr=0, i2c_wdata=0, init_over=0, init_err=0. State = RST_HOLD; all counters = 0.
- State machine (all outputs registered):
  - RST_HOLD: rstn_out=0 for exactly RST_HOLD_CYC cycles, then RST_WAIT.
  - RST_WAIT: rstn_out=1. Wait RST_WAIT_CYC cycles, then FETCH with tbl_idx=0.
  - FETCH: lasts 1 cycle (ROM latency), then LOAD.
  - LOAD: sample tbl_data.
    - If [23:8]==16'hFFFF: DELAY, with length [7:0]*DLY_UNIT_CYC cycles. A value of 0 gives a 0-cycle delay (goes straight to NEXT).
    - Otherwise: latch i2c_reg_addr/i2c_wdata, clear the retry counter, go to WRITE.
  - WRITE: i2c_req=1. Address and data are held constant until i2c_done.
    - On i2c_done & !i2c_nack: deassert i2c_req the following cycle, go to NEXT.
    - On i2c_done & i2c_nack: retry_cnt+1.
      - If the new count == MAX_RETRY: go to ERROR.
      - Else: GAP (i2c_req=0 for exactly 1 cycle), then WRITE again with the same data.
  - DELAY: count down, then NEXT.
  - NEXT: if tbl_idx==TBL_LEN-1, go to DONE. Else tbl_idx+1, go to FETCH.
  - DONE: init_over=1 (sticky).
  - ERROR: init_err=1 (sticky). i2c_req=0; rstn_out stays 1.
- Handshake rules:
  - i2c_done is ignored in every state except WRITE.
  - i2c_req never drops before i2c_done.
  - The minimum gap between consecutive requests is 1 cycle.
- restart:
  - Honoured only in DONE or ERROR. It clears init_over, init_err and tbl_idx, then enters RST_HOLD (full reset pulse again).
  - Ignored in all other states.
- init_over and init_err are mutually exclusive.
- Asynchronous reset mid-transfer: i2c_req drops immediately and the sequence restarts from RST_HOLD. The I2C master is reset from the same rst_n.
- Widths:
  - Delay counter is wide enough for 255*DLY_UNIT_CYC.
  - Reset counters are sized to max(RST_HOLD_CYC, RST_WAIT_CYC).
  - Retry counter is sized to MAX_RETRY.
  - tbl_idx never wraps; it stops at TBL_LEN-1.

Test Plan:
- Power-up, params RST_HOLD_CYC=10, RST_WAIT_CYC=20 -> rstn_out low exactly 10 cycles after reset release; first i2c_req exactly 20+2 cycles after rstn_out rises.
- TBL_LEN=4, table {0x1281:0x04, 0x0003:0x25, 0x0004:0x31, 0x0005:0x1A}, master acks after 5 cycles -> 4 requests in order with matching addr/data, stable while req high; init_over=1 one cycle after the last NEXT; tbl_idx ends at 3.
- Entry 1 = 0xFFFF:0x03, DLY_UNIT_CYC=8 -> 24-cycle gap with no i2c_req between entries 0 and 2; delay entry 0xFFFF:0x00 -> no extra wait.
- Entry 0 NACKed twice then acked, MAX_RETRY=3 -> 3 requests for the same addr/data, each separated by a 1-cycle low gap; sequence continues and init_over=1.
- Entry 2 NACKed 3 times -> init_err=1, init_over=0, no further requests; restart pulse -> rstn_out low 10 cycles, sequence reruns from idx 0; restart pulsed during WRITE -> no effect.
- rst_n asserted while i2c_req=1 -> i2c_req=0 and rstn_out=0 in the same cycle; stray i2c_done during RST_WAIT -> ignored.
